// File: rtl/fsm_pattern_search.sv
// Masked pattern search: once started, scans data_in for up to MAX_CYCLES cycles and
// reports match / timeout / abort with a fixed-length done strobe and the deciding cycle.
module fsm_pattern_search #(
  parameter  int DATA_W      = 4,
  parameter  int MAX_CYCLES  = 100,
  parameter  int DONE_CYCLES = 2,
  parameter  int MATCH_COUNT = 1,
  localparam int CNT_W       = $clog2(MAX_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] mask,
  input  logic [DATA_W-1:0] data_in,
  input  logic              abort,
  output logic              avail,
  output logic              done,
  output logic [1:0]        flag,
  output logic [CNT_W-1:0]  match_idx
);

  localparam int DONE_W = $clog2(DONE_CYCLES + 1);

  localparam logic [CNT_W-1:0]  MAX_N     = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0]  MATCH_N   = CNT_W'(MATCH_COUNT);
  localparam logic [DONE_W-1:0] DONE_LAST = DONE_W'(DONE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_GAP,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    FLAG_TIMEOUT = 2'b00,
    FLAG_MATCH   = 2'b01,
    FLAG_ABORT   = 2'b10
  } flag_e;

  state_e             state_q,   state_d;
  flag_e              flag_q,    flag_d;
  logic [DATA_W-1:0]  pattern_q, pattern_d;
  logic [DATA_W-1:0]  mask_q,    mask_d;
  logic [CNT_W-1:0]   cyc_q,     cyc_d;
  logic [CNT_W-1:0]   hit_q,     hit_d;
  logic [CNT_W-1:0]   idx_q,     idx_d;
  logic [DONE_W-1:0]  dcnt_q,    dcnt_d;
  logic               avail_q;
  logic               done_q;

  logic               hit_now;
  logic [CNT_W-1:0]   cyc_next;
  logic [CNT_W-1:0]   hit_next;

  assign hit_now  = ((data_in & mask_q) == (pattern_q & mask_q));
  assign cyc_next = cyc_q + CNT_W'(1);
  assign hit_next = hit_q + CNT_W'(hit_now);

  // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    flag_d    = flag_q;
    pattern_d = pattern_q;
    mask_d    = mask_q;
    cyc_d     = cyc_q;
    hit_d     = hit_q;
    idx_d     = idx_q;
    dcnt_d    = dcnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SEARCH;
          pattern_d = pattern;
          mask_d    = mask;
          cyc_d     = '0;
          hit_d     = '0;
          flag_d    = FLAG_TIMEOUT;
          idx_d     = '0;
        end
      end
      S_SEARCH: begin
        cyc_d = cyc_next;
        hit_d = hit_next;
        // Abort outranks a same-edge match, and a match on the last cycle outranks timeout.
        if (abort) begin
          state_d = S_GAP;
          flag_d  = FLAG_ABORT;
          idx_d   = '0;
        end else if (hit_next == MATCH_N) begin
          state_d = S_GAP;
          flag_d  = FLAG_MATCH;
          idx_d   = cyc_next;
        end else if (cyc_next == MAX_N) begin
          state_d = S_GAP;
          flag_d  = FLAG_TIMEOUT;
          idx_d   = '0;
        end
        if (state_d == S_GAP) begin
          cyc_d = '0;
          hit_d = '0;
        end
      end
      S_GAP: begin
        state_d = S_DONE;
        dcnt_d  = '0;
      end
      S_DONE: begin
        if (dcnt_q == DONE_LAST) begin
          state_d = S_IDLE;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DONE_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      flag_q  <= FLAG_TIMEOUT;
      cyc_q   <= '0;
      hit_q   <= '0;
      idx_q   <= '0;
      dcnt_q  <= '0;
      avail_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      cyc_q   <= cyc_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      avail_q <= (state_d == S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  // NOTE: pattern/mask are always loaded on an accepted start before they are used, so they carry no reset.
  always_ff @(posedge clk) begin
    pattern_q <= pattern_d;
    mask_q    <= mask_d;
  end

  assign avail     = avail_q;
  assign done      = done_q;
  assign flag      = flag_q;
  assign match_idx = idx_q;

endmodule

// File: tb/tb_fsm_pattern_search.sv
// Scoreboard bench for fsm_pattern_search: instance 0 uses defaults, instance 1 uses
// MATCH_COUNT=3 and DONE_CYCLES=4. Expected results are queued by the stimulus and checked on done.
module tb_fsm_pattern_search;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_s   [2];
  logic       abort_s   [2];
  logic [3:0] pattern_s [2];
  logic [3:0] mask_s    [2];
  logic [3:0] data_s    [2];
  logic       avail_s   [2];
  logic       done_s    [2];
  logic [1:0] flag_s    [2];
  logic [6:0] idx_s     [2];

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;

  typedef struct {
    int inst;
    int flag;
    int idx;
    int done_edge;
    int done_len;
  } exp_t;

  exp_t exp_q [$];
  exp_t cur [2];
  bit   active [2];
  int   rise_edge [2];
  logic prev_done [2];

  fsm_pattern_search #(.MATCH_COUNT(1), .DONE_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .pattern(pattern_s[0]),
    .mask(mask_s[0]), .data_in(data_s[0]), .abort(abort_s[0]),
    .avail(avail_s[0]), .done(done_s[0]), .flag(flag_s[0]), .match_idx(idx_s[0])
  );

  fsm_pattern_search #(.MATCH_COUNT(3), .DONE_CYCLES(4)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .pattern(pattern_s[1]),
    .mask(mask_s[1]), .data_in(data_s[1]), .abort(abort_s[1]),
    .avail(avail_s[1]), .done(done_s[1]), .flag(flag_s[1]), .match_idx(idx_s[1])
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int inst, input int flag, input int idx,
                          input int done_edge, input int done_len);
    exp_t e;
    e.inst = inst; e.flag = flag; e.idx = idx;
    e.done_edge = done_edge; e.done_len = done_len;
    exp_q.push_back(e);
  endtask

  // Accept a search on instance i; e0 is the absolute number of the accepting edge.
  task automatic start_search(input int i, input logic [3:0] pat, input logic [3:0] msk,
                              output int e0);
    pattern_s[i] = pat;
    mask_s[i]    = msk;
    start_s[i]   = 1'b1;
    step();
    e0 = edge_cnt;
    start_s[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    for (int n = 0; n < 300; n++) begin
      if (avail_s[i]) return;
      step();
    end
    check($sformatf("wait_idle_%0d", i), int'(avail_s[i]), 1);
  endtask

  function automatic logic [3:0] rand_except(input logic [3:0] bad);
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    if (v == bad) v = ~bad;
    return v;
  endfunction

  // Monitor: on each done pulse, pop the expectation and compare result, timing and length.
  initial begin
    prev_done[0] = 1'b0;
    prev_done[1] = 1'b0;
    active[0] = 1'b0;
    active[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (done_s[i] === 1'b1 && prev_done[i] !== 1'b1) begin
          rise_edge[i] = edge_cnt + 1;
          if (exp_q.size() == 0 || exp_q[0].inst != i) begin
            check($sformatf("unexpected_done_%0d", i), int'(done_s[i]), 0);
          end else begin
            cur[i] = exp_q.pop_front();
            active[i] = 1'b1;
            check($sformatf("flag_%0d", i), int'(flag_s[i]), cur[i].flag);
            check($sformatf("match_idx_%0d", i), int'(idx_s[i]), cur[i].idx);
            check($sformatf("done_edge_%0d", i), rise_edge[i], cur[i].done_edge);
            check($sformatf("avail_in_done_%0d", i), int'(avail_s[i]), 0);
          end
        end else if (done_s[i] !== 1'b1 && prev_done[i] === 1'b1 && active[i]) begin
          check($sformatf("done_len_%0d", i), edge_cnt + 1 - rise_edge[i], cur[i].done_len);
          check($sformatf("avail_after_done_%0d", i), int'(avail_s[i]), 1);
          active[i] = 1'b0;
        end
        prev_done[i] = done_s[i];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int errs;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0;
      pattern_s[i] = '0; mask_s[i] = '0; data_s[i] = '0;
    end

    // Reset: outputs take reset values after the first reset edge.
    step();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_avail_%0d", i), int'(avail_s[i]), 1);
      check($sformatf("rst_done_%0d", i), int'(done_s[i]), 0);
      check($sformatf("rst_flag_%0d", i), int'(flag_s[i]), 0);
      check($sformatf("rst_idx_%0d", i), int'(idx_s[i]), 0);
    end
    step();
    step();
    reset = 1'b0;

    // Single match at E37.
    start_search(0, 4'b1011, 4'hF, e0);
    push_exp(0, 1, 37, e0 + 39, 2);
    errs = int'(avail_s[0] || done_s[0]);
    for (int k = 1; k <= 37; k++) begin
      data_s[0] = (k == 37) ? 4'b1011 : rand_except(4'b1011);
      step();
      if (k < 37) errs += int'(avail_s[0] || done_s[0]);
    end
    check("match_busy", errs, 0);
    data_s[0] = 4'b0000;
    wait_idle(0);

    // Timeout after 100 non-matching samples.
    start_search(0, 4'b1011, 4'hF, e0);
    push_exp(0, 0, 0, e0 + 102, 2);
    errs = int'(avail_s[0] || done_s[0]);
    for (int k = 1; k <= 100; k++) begin
      data_s[0] = rand_except(4'b1011);
      step();
      errs += int'(avail_s[0] || done_s[0]);
    end
    check("timeout_busy", errs, 0);
    wait_idle(0);

    // Abort in IDLE is ignored.
    abort_s[0] = 1'b1;
    step();
    abort_s[0] = 1'b0;
    step();
    check("idle_abort_avail", int'(avail_s[0]), 1);
    check("idle_abort_flag", int'(flag_s[0]), 0);

    // Abort wins over a same-edge match at E12.
    start_search(0, 4'b0101, 4'hF, e0);
    push_exp(0, 2, 0, e0 + 14, 2);
    for (int k = 1; k <= 12; k++) begin
      data_s[0]  = (k == 12) ? 4'b0101 : rand_except(4'b0101);
      abort_s[0] = (k == 12);
      step();
    end
    abort_s[0] = 1'b0;
    wait_idle(0);

    // start held high: mask=0 matches at E1, second search accepted back-to-back at E5.
    pattern_s[0] = 4'b0110;
    mask_s[0]    = 4'b0000;
    start_s[0]   = 1'b1;
    step();
    e0 = edge_cnt;
    push_exp(0, 1, 1, e0 + 3, 2);
    push_exp(0, 1, 1, e0 + 8, 2);
    for (int k = 1; k <= 5; k++) step();
    start_s[0] = 1'b0;
    check("b2b_accept", int'(avail_s[0]), 0);
    wait_idle(0);

    // Match on the last cycle (E100); start pulsed during DONE is ignored.
    start_search(0, 4'b0011, 4'hF, e0);
    push_exp(0, 1, 100, e0 + 102, 2);
    for (int k = 1; k <= 100; k++) begin
      data_s[0] = (k == 100) ? 4'b0011 : rand_except(4'b0011);
      step();
    end
    step();
    start_s[0] = 1'b1;
    step();
    step();
    start_s[0] = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("done_start_ignored", int'(avail_s[0]), 1);
    check("hold_flag", int'(flag_s[0]), 1);
    check("hold_idx", int'(idx_s[0]), 100);

    // Third hit at E20 with MATCH_COUNT=3, DONE_CYCLES=4; inputs changed after capture.
    start_search(1, 4'b1001, 4'b1100, e0);
    pattern_s[1] = 4'b0000;
    mask_s[1]    = 4'b1111;
    push_exp(1, 1, 20, e0 + 22, 4);
    for (int k = 1; k <= 20; k++) begin
      case (k)
        5:       data_s[1] = 4'b1000;
        9:       data_s[1] = 4'b1011;
        20:      data_s[1] = 4'b1001;
        default: data_s[1] = (k % 2 == 0) ? 4'b0110 : 4'b1101;
      endcase
      step();
    end
    data_s[1] = 4'b0000;
    wait_idle(1);

    // Reset at E50 of a search: idle with reset values next edge, no done pulse.
    start_search(0, 4'b1111, 4'hF, e0);
    for (int k = 1; k <= 50; k++) begin
      data_s[0] = 4'b0000;
      reset = (k == 50);
      step();
    end
    reset = 1'b0;
    check("midrst_avail", int'(avail_s[0]), 1);
    check("midrst_done", int'(done_s[0]), 0);
    check("midrst_flag", int'(flag_s[0]), 0);
    check("midrst_idx", int'(idx_s[0]), 0);
    for (int k = 0; k < 10; k++) step();
    check("midrst_stay_idle", int'(avail_s[0]), 1);

    check("exp_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_pattern_search.md
Name: fsm_pattern_search

Overview:
- Parametrised successor to the FSM5 sequence detector.
- Accepts a start request while available, then scans `data_in` for a masked pattern for up to MAX_CYCLES cycles.
- Reports the result with a fixed-length done pulse and a flag code: match, timeout or abort.
- Adds over FSM5: programmable pattern and mask, Nth-occurrence matching, an abort input, and a reported match index.

Parameters:
- DATA_W, 4: width of data_in, pattern and mask.
- MAX_CYCLES, 100: search window length in cycles (>=1).
- DONE_CYCLES, 2: number of cycles done is held high (>=1).
- MATCH_COUNT, 1: number of matching samples required to declare a match (1..MAX_CYCLES).
- CNT_W, $clog2(MAX_CYCLES+1): width of match_idx and of the internal counters (derived, not overridden).

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: search request; accepted only when avail=1.
- pattern, in, DATA_W: pattern to find; captured on the accepted start.
- mask, in, DATA_W: bit compare enable (1 = compare); captured on the accepted start.
- data_in, in, DATA_W: scanned data, sampled every clock edge in SEARCH.
- abort, in, 1: terminates the search; honoured only in SEARCH.
- avail, out, 1: block idle, ready to accept start.
- done, out, 1: result strobe, high for DONE_CYCLES consecutive cycles.
- flag, out, 2: result code. 00 = timeout, 01 = match, 10 = abort, 11 = never driven.
- match_idx, out, CNT_W: search cycle (1..MAX_CYCLES) of the deciding match; 0 for timeout or abort.

Behaviour:
- All outputs are registered. Reset is synchronous, active-high; while reset=1 the block enters IDLE at the next edge.
- Reset values: avail=1, done=0, flag=00, match_idx=0. All counters are cleared.
- States:
  - IDLE: avail=1, done=0.
  - SEARCH: avail=0, done=0.
  - GAP: avail=0, done=0.
  - DONE: avail=0, done=1.
- IDLE -> SEARCH: at edge E0 with start=1.
  - Captures pattern and mask.
  - Clears the cycle counter, the hit counter, flag (to 00) and match_idx (to 0).
- Search window: edges E1..E_MAX_CYCLES, one sample per edge. A hit is `(data_in & mask_q) == (pattern_q & mask_q)`.
  - mask=0 makes every sample a hit.
- Match: at edge Ek, when the hit counter reaches MATCH_COUNT.
  - Next state GAP, flag=01, match_idx=k.
- Timeout: at edge E_MAX_CYCLES with no match.
  - Next state GAP, flag=00, match_idx=0.
- Abort: abort=1 at any edge Ek in SEARCH.
  - Next state GAP, flag=10, match_idx=0.
- Priority at a single edge: abort > match > timeout. A match at E_MAX_CYCLES reports 01.
- GAP lasts exactly one cycle, then DONE.
- DONE lasts DONE_CYCLES cycles, then IDLE.
- Cycle-level timeline for a terminating event at Ek, sampled at later edges:
  - E(k+1): done=0, avail=0.
  - E(k+2) .. E(k+1+DONE_CYCLES): done=1.
  - E(k+2+DONE_CYCLES): done=0, avail=1.
- Defaults example: start at E0 with no match gives done=1 at E102 and E103, and avail=1 at E104.
- avail and done are never both 1.
- flag and match_idx hold their values from the terminating edge through DONE and IDLE, until the next accepted start clears them.
- Ignored inputs:
  - start while avail=0 is ignored and not queued.
  - abort outside SEARCH is ignored.
  - pattern and mask changes after capture have no effect.
- start held high continuously: a new search is accepted on the first edge with avail=1, i.e. back-to-back with no extra idle cycle.
- Reset mid-SEARCH, GAP or DONE: IDLE at the next edge with the reset values above, and no done pulse.
- Counter widths: the cycle counter counts 1..MAX_CYCLES and the hit counter 0..MATCH_COUNT. Neither wraps; both saturate and then clear on state exit.

Test Plan:
1. Reset
   - Stimulus: reset=1 for 3 cycles, then 0.
   - Required: avail=1, done=0, flag=00, match_idx=0 at the edge after the first reset edge.
2. Single match, defaults
   - Stimulus: pattern=4'b1011, mask=4'hF, start at E0, data_in=4'b1011 first sampled at E37.
   - Required: done=1 at E39 and E40, flag=01, match_idx=37, avail=1 at E41.
3. Timeout
   - Stimulus: random data_in excluding 4'b1011 for 100 cycles.
   - Required: done=1 at E102 and E103, flag=00, match_idx=0; avail=0 and done=0 throughout E1..E101.
4. Nth match
   - Stimulus: MATCH_COUNT=3, mask=4'b1100, pattern=4'b10xx; hits at E5, E9 and E20.
   - Required: flag=01, match_idx=20, done=1 at E22 and E23.
5. Abort priority
   - Stimulus: abort=1 and a matching sample together at E12.
   - Required: flag=10, match_idx=0, done=1 at E14 and E15. An abort pulse while in IDLE has no effect.
6. Edge cases
   - Match at E100: flag=01, match_idx=100.
   - start pulsed during DONE: ignored.
   - reset asserted at E50 of SEARCH: avail=1 at E51, with no done pulse.
   - DONE_CYCLES=4 build: done high for exactly 4 cycles.
